aes_dec_state: RTL
==================

# aes_dec_state

Iterative AES inverse cipher (FIPS-197 §5.3) that consumes the round-key schedule produced by the key-expansion block and decrypts one 128-bit block. It computes one round per clock. It reads the schedule in reverse order, from the last round key down to round key 0. It sits beside the key expander: the expander's `KExp` and `Ready_out` outputs feed this block's `KExp` and `Key_ready` inputs.

## Interface
- `Nb`, 4, columns per state; taken from `aes_const`.
- `Nk`, 4, key words (4/6/8); taken from `aes_const`.
- `Nr`, 10, rounds (10/12/14); taken from `aes_const`.
- `rst`  in  1  asynchronous, active-low reset.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `Data_in`  in  `[7:0] [0:15]`  ciphertext. Byte `4c+r` is row `r`, column `c`.
- `KExp`  in  `[31:0] [0:Nb*(Nr+1)-1]`  expanded key. In word `w[i]`, bits `[31:24]` are row 0.
- `InvSBox`  in  `[7:0] [0:255]`  inverse S-box table.
- `Key_ready`  in  1  level signal: the schedule is valid and stable.
- `Enable`  in  1  start request, sampled only in IDLE.
- `Data_out`  out  `[7:0] [0:15]`  plaintext, same byte order as `Data_in`.
- `Ready_out`  out  1  one-cycle completion pulse.
- `Error`  out  1  only present with `AES_DEC_KEYCHK_EN` (see Configuration).

## Operation
- **Registers**
  - `state` (4 bits): 0 = IDLE, 1 = ROUND, 2 = FINAL.
  - `round` (4 bits).
  - `st` (128-bit working state).
  - `Data_out` and `Ready_out`, both registered.
- **IDLE**
  - On `Enable == 1`:
    - `st <= Data_in ^ {w[Nr*Nb] .. w[Nr*Nb+3]}`.
    - `round <= Nr-1`.
    - Go to ROUND.
  - Otherwise hold.
- **ROUND**, one full inverse round per cycle.
  - Operation: `st <= InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(st)), w[round*Nb .. round*Nb+3]))`.
  - `round` decrements by 1 each cycle.
  - When `round == 1` in this cycle, go to FINAL next.
- **FINAL**
  - Operation: `Data_out <= AddRoundKey(InvSubBytes(InvShiftRows(st)), w[0..3])`. No InvMixColumns.
  - `Ready_out <= 1`.
  - Go to IDLE.
- **Primitive definitions**
  - InvShiftRows: row `r` is rotated right by `r` columns.
  - InvMixColumns: matrix `{0e,0b,0d,09}` over GF(2^8) with polynomial `0x11b`. It is built from xtime chains; no lookup tables.
- `Enable` is ignored outside IDLE. A request made while busy is dropped, not queued.
- `Data_in` is captured only in the accepting cycle. It may change afterwards.
- `KExp` must stay stable from the accepting cycle through FINAL. The block does not latch it.
- `Data_out` holds its value until the next FINAL.
- All arithmetic is modulo 2^8 per byte. `round` never wraps: its minimum used value is 1 in ROUND and 0 in FINAL.

## Timing
- Reset values: `state = 0`, `round = 0`, `st = 0`, `Data_out = all 0`, `Ready_out = 0`, `Error = 0`.
- Reset mid-operation aborts the block immediately to IDLE. No `Ready_out` is produced for the aborted block.
- Latency: `Enable` sampled high at edge T gives `Ready_out == 1` during the cycle after edge T+Nr.
  - AES-128: 10 edges.
  - AES-192: 12 edges.
  - AES-256: 14 edges.
- `Ready_out` is high for exactly one cycle. In that same cycle `Data_out` is valid and `state == 0`.
- Throughput: `Enable` may be high in the `Ready_out` cycle. It is accepted, giving one block per Nr+1 cycles.
- `Enable` held high continuously gives back-to-back blocks with no idle gap beyond that one cycle.

## Configuration
- Macro: `AES_DEC_KEYCHK_EN`.
- **Defined**
  - `Enable` in IDLE is accepted only if `Key_ready == 1`.
  - `Enable == 1` with `Key_ready == 0` is ignored, and `Error` is set on the next edge.
  - `Error` is sticky. It clears on the next accepted `Enable` or on reset.
- **Undefined**
  - `Key_ready` is unused and `Enable` alone starts decryption.
  - The `Error` port is absent.
  - Correctness is the system's responsibility.

## Test plan
- **FIPS-197 C.1**: key `000102..0f`, expanded; `Data_in = 69c4e0d86a7b0430d8cdb78070b4c55a`; `Enable` for 1 cycle -> after 10 edges `Ready_out` pulses once and `Data_out = 00112233445566778899aabbccddeeff`.
- **FIPS-197 B**: key `2b7e151628aed2a6abf7158809cf4f3c`, ct `3925841d02dc09fbdc118597196a0b32` -> `Data_out = 3243f6a8885a308d313198a2e0370734`. Repeat the C.2/C.3 vectors under 192/256-bit `aes_const` builds and check latency 12/14.
- **Back-to-back**: `Enable` held high with two ciphertexts -> two `Ready_out` pulses 11 cycles apart, both plaintexts correct. `Enable` pulses inside ROUND are ignored.
- **Reset abort**: `rst` low at cycle 5 of a decryption -> asynchronously `Data_out = 0` and `Ready_out = 0`. After release, a new `Enable` decrypts correctly.
- **Key check** (with `AES_DEC_KEYCHK_EN`): `Enable` with `Key_ready = 0` -> no `Ready_out`, `Error = 1`. Then `Key_ready = 1` and `Enable` -> `Error = 0` and correct result.
- **Data hold**: change `Data_in` during ROUND and after `Ready_out` -> `Data_out` is unchanged until the next FINAL.

Source files
------------

// File: rtl/aes_dec_state_if.sv
// Bus bundle for aes_dec_state: ciphertext, key schedule and inverse S-box in, plaintext out.
// The Error line exists only when AES_DEC_KEYCHK_EN is defined.
interface aes_dec_state_if #(
  parameter int NB = 4,
  parameter int NK = 4,
  parameter int NR = NK + 6
);
  logic [0:15][7:0]           Data_in;
  logic [0:NB*(NR+1)-1][31:0] KExp;
  logic [0:255][7:0]          InvSBox;
  logic                       Key_ready;
  logic                       Enable;
  logic [0:15][7:0]           Data_out;
  logic                       Ready_out;
`ifdef AES_DEC_KEYCHK_EN
  logic                       Error;

  modport master (output Data_in, KExp, InvSBox, Key_ready, Enable,
                  input  Data_out, Ready_out, Error);
  modport slave  (input  Data_in, KExp, InvSBox, Key_ready, Enable,
                  output Data_out, Ready_out, Error);
`else
  modport master (output Data_in, KExp, InvSBox, Key_ready, Enable,
                  input  Data_out, Ready_out);
  modport slave  (input  Data_in, KExp, InvSBox, Key_ready, Enable,
                  output Data_out, Ready_out);
`endif
endinterface

// File: rtl/aes_dec_state.sv
// Iterative AES inverse cipher: one round per clock, key schedule walked from last word to first.
// AES_DEC_KEYCHK_EN gates starts on Key_ready and adds a sticky Error output.
module aes_dec_state #(
  parameter int NB = 4,
  parameter int NK = 4,
  parameter int NR = NK + 6
) (
  input  logic           clk,
  input  logic           rst,
  aes_dec_state_if.slave bus
);
  localparam int            KW          = $clog2(NB * (NR + 1));
  localparam logic [KW-1:0] KW_LAST     = KW'(NR * NB);
  localparam logic [3:0]    ROUND_FIRST = 4'(NR - 1);

  typedef logic [0:15][7:0] blk_t;
  typedef logic [0:3][7:0]  col_t;
  typedef enum logic [3:0] {S_IDLE = 4'd0, S_ROUND = 4'd1, S_FINAL = 4'd2} state_t;

  state_t        r_state, w_state_nxt;
  logic [3:0]    r_round, w_round_nxt;
  blk_t          r_st, w_st_nxt;
  blk_t          r_data_out, w_data_out_nxt;
  logic          r_ready, w_ready_nxt;
  logic          w_accept;
  logic [KW-1:0] w_kbase;
  blk_t          w_rk, w_isr, w_isb, w_ark, w_imc;
`ifdef AES_DEC_KEYCHK_EN
  logic          r_error, w_error_nxt;
`else
  logic          w_unused;
`endif

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Constant multiply summed from the a, 2a, 4a, 8a chain; bit n of k selects the 2^n term.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] k);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{k[0]}} & a) ^ ({8{k[1]}} & x2) ^ ({8{k[2]}} & x4) ^ ({8{k[3]}} & x8);
  endfunction

  function automatic col_t inv_mix_col(input col_t a);
    col_t o;
    o[0] = gmul(a[0], 4'he) ^ gmul(a[1], 4'hb) ^ gmul(a[2], 4'hd) ^ gmul(a[3], 4'h9);
    o[1] = gmul(a[0], 4'h9) ^ gmul(a[1], 4'he) ^ gmul(a[2], 4'hb) ^ gmul(a[3], 4'hd);
    o[2] = gmul(a[0], 4'hd) ^ gmul(a[1], 4'h9) ^ gmul(a[2], 4'he) ^ gmul(a[3], 4'hb);
    o[3] = gmul(a[0], 4'hb) ^ gmul(a[1], 4'hd) ^ gmul(a[2], 4'h9) ^ gmul(a[3], 4'he);
    return o;
  endfunction

  function automatic blk_t inv_shift_rows(input blk_t s);
    return {s[0],  s[13], s[10], s[7],
            s[4],  s[1],  s[14], s[11],
            s[8],  s[5],  s[2],  s[15],
            s[12], s[9],  s[6],  s[3]};
  endfunction

  // Whitening key (last four words) while idle, otherwise the key of the current round.
  always_comb begin
    if (r_state == S_IDLE) begin
      w_kbase = KW_LAST;
    end else begin
      w_kbase = KW'(r_round) * KW'(NB);
    end
  end

  assign w_rk  = {bus.KExp[w_kbase],          bus.KExp[w_kbase + KW'(1)],
                  bus.KExp[w_kbase + KW'(2)], bus.KExp[w_kbase + KW'(3)]};
  assign w_isr = inv_shift_rows(r_st);

  for (genvar i = 0; i < 16; i++) begin : g_isb
    assign w_isb[i] = bus.InvSBox[w_isr[i]];
  end

  assign w_ark = w_isb ^ w_rk;

  for (genvar c = 0; c < 4; c++) begin : g_imc
    assign w_imc[4*c +: 4] = inv_mix_col(w_ark[4*c +: 4]);
  end

`ifdef AES_DEC_KEYCHK_EN
  assign w_accept = bus.Enable & bus.Key_ready;
`else
  assign w_accept = bus.Enable;
  assign w_unused = bus.Key_ready;
`endif

  // Next-state and datapath selection; Enable outside IDLE is simply dropped.
  always_comb begin
    w_state_nxt    = r_state;
    w_round_nxt    = r_round;
    w_st_nxt       = r_st;
    w_data_out_nxt = r_data_out;
    w_ready_nxt    = 1'b0;
`ifdef AES_DEC_KEYCHK_EN
    w_error_nxt    = r_error;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_st_nxt    = bus.Data_in ^ w_rk;
          w_round_nxt = ROUND_FIRST;
          w_state_nxt = S_ROUND;
        end else begin
          w_state_nxt = S_IDLE;
        end
`ifdef AES_DEC_KEYCHK_EN
        if (bus.Enable) begin
          w_error_nxt = ~bus.Key_ready;
        end else begin
          w_error_nxt = r_error;
        end
`endif
      end
      S_ROUND: begin
        w_st_nxt    = w_imc;
        w_round_nxt = r_round - 4'd1;
        if (r_round == 4'd1) begin
          w_state_nxt = S_FINAL;
        end else begin
          w_state_nxt = S_ROUND;
        end
      end
      S_FINAL: begin
        w_data_out_nxt = w_ark;
        w_ready_nxt    = 1'b1;
        w_state_nxt    = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_round_nxt = 4'd0;
      end
    endcase
  end

  // State and output registers; reset abandons any block in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_round    <= 4'd0;
      r_st       <= 128'd0;
      r_data_out <= 128'd0;
      r_ready    <= 1'b0;
`ifdef AES_DEC_KEYCHK_EN
      r_error    <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_round    <= w_round_nxt;
      r_st       <= w_st_nxt;
      r_data_out <= w_data_out_nxt;
      r_ready    <= w_ready_nxt;
`ifdef AES_DEC_KEYCHK_EN
      r_error    <= w_error_nxt;
`endif
    end
  end

  assign bus.Data_out  = r_data_out;
  assign bus.Ready_out = r_ready;
`ifdef AES_DEC_KEYCHK_EN
  assign bus.Error     = r_error;
`endif
endmodule
